// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: init hand-off, write/read grants, periodic auto-refresh.
// Define ARB_RD_PRIORITY_EN to favour read over write on simultaneous requests.
module sdram_arbit #(
    parameter int REF_PERIOD = 780,
    parameter int TRP        = 2,
    parameter int TRC        = 7,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_end,
    input  logic [3:0]            init_cmd,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic                  wr_rq,
    input  logic                  wr_end_flag,
    input  logic [3:0]            wr_cmd,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [1:0]            wr_bank_addr,
    input  logic                  rd_rq,
    input  logic                  rd_end_flag,
    input  logic [3:0]            rd_cmd,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [1:0]            rd_bank_addr,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic                  ref_rq,
    output logic                  ref_overrun,
    output logic [3:0]            sdram_cmd,
    output logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic [1:0]            sdram_bank
);
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    localparam int CW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam int AW = $clog2(TRP + TRC + 1);
    localparam logic [CW-1:0] REF_LAST = CW'(REF_PERIOD - 1);
    localparam logic [AW-1:0] A_TRP    = AW'(TRP);
    localparam logic [AW-1:0] A_LAST   = AW'(TRP + TRC - 1);
    // A10 high during PRECHARGE selects all banks.
    localparam logic [ADDR_WIDTH-1:0] PRE_ALL = ADDR_WIDTH'(1024);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_ARBIT,
        ST_AREF,
        ST_WRITE,
        ST_READ
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         timer_q, timer_d;
    logic [AW-1:0]         a_q, a_d;
    logic                  ref_rq_q, ref_rq_d;
    logic                  ovr_q, ovr_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [3:0]            cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            bank_q, bank_d;
    logic                  wrap;
    logic                  take_ref;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        a_d      = '0;
        ref_rq_d = ref_rq_q;
        ovr_d    = ovr_q;
        wr_en_d  = 1'b0;
        rd_en_d  = 1'b0;
        cmd_d    = CMD_NOP;
        addr_d   = '0;
        bank_d   = '0;
        wrap     = 1'b0;
        take_ref = 1'b0;

        if (state_q == ST_INIT) begin
            timer_d = '0;
        end else if (timer_q == REF_LAST) begin
            timer_d = '0;
            wrap    = 1'b1;
        end else begin
            timer_d = timer_q + CW'(1);
        end

        case (state_q)
            ST_INIT: begin
                cmd_d  = init_cmd;
                addr_d = init_addr;
                if (init_end) state_d = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (ref_rq_q) begin
                    state_d  = ST_AREF;
                    take_ref = 1'b1;
`ifdef ARB_RD_PRIORITY_EN
                end else if (rd_rq) begin
                    state_d = ST_READ;
                    rd_en_d = 1'b1;
                end else if (wr_rq) begin
                    state_d = ST_WRITE;
                    wr_en_d = 1'b1;
`else
                end else if (wr_rq) begin
                    state_d = ST_WRITE;
                    wr_en_d = 1'b1;
                end else if (rd_rq) begin
                    state_d = ST_READ;
                    rd_en_d = 1'b1;
`endif
                end
            end
            ST_WRITE: begin
                cmd_d  = wr_cmd;
                addr_d = wr_addr;
                bank_d = wr_bank_addr;
                if (wr_end_flag) state_d = ST_ARBIT;
            end
            ST_READ: begin
                cmd_d  = rd_cmd;
                addr_d = rd_addr;
                bank_d = rd_bank_addr;
                if (rd_end_flag) state_d = ST_ARBIT;
            end
            ST_AREF: begin
                if (a_q == '0) begin
                    cmd_d  = CMD_PRE;
                    addr_d = PRE_ALL;
                end else if (a_q == A_TRP) begin
                    cmd_d = CMD_AREF;
                end
                if (a_q == A_LAST) state_d = ST_ARBIT;
                else               a_d     = a_q + AW'(1);
            end
            default: state_d = ST_INIT;
        endcase

        // A wrap on the AREF entry cycle outranks the clear.
        if (wrap) begin
            if (ref_rq_q) ovr_d = 1'b1;
            ref_rq_d = 1'b1;
        end else if (take_ref) begin
            ref_rq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            timer_q  <= '0;
            a_q      <= '0;
            ref_rq_q <= 1'b0;
            ovr_q    <= 1'b0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            cmd_q    <= CMD_NOP;
            addr_q   <= '0;
            bank_q   <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            a_q      <= a_d;
            ref_rq_q <= ref_rq_d;
            ovr_q    <= ovr_d;
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            bank_q   <= bank_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign rd_en       = rd_en_q;
    assign ref_rq      = ref_rq_q;
    assign ref_overrun = ovr_q;
    assign sdram_cmd   = cmd_q;
    assign sdram_addr  = addr_q;
    assign sdram_bank  = bank_q;
endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed test-plan steps plus a randomized stretch,
// all checked cycle by cycle against a behavioural reference model.
module tb_sdram_arbit;
    localparam int AW  = 12;
    localparam int P   = 780;
    localparam int TRP = 2;
    localparam int TRC = 7;
`ifdef ARB_RD_PRIORITY_EN
    localparam bit RD_PRI = 1'b1;
`else
    localparam bit RD_PRI = 1'b0;
`endif
    localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, ARF = 4'b0001;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_end = 1'b0;
    logic [3:0]    init_cmd = 4'b0000;
    logic [AW-1:0] init_addr = '0;
    logic          wr_rq = 1'b0, wr_end_flag = 1'b0;
    logic [3:0]    wr_cmd = 4'b0000;
    logic [AW-1:0] wr_addr = '0;
    logic [1:0]    wr_bank_addr = '0;
    logic          rd_rq = 1'b0, rd_end_flag = 1'b0;
    logic [3:0]    rd_cmd = 4'b0000;
    logic [AW-1:0] rd_addr = '0;
    logic [1:0]    rd_bank_addr = '0;
    logic          wr_en, rd_en, ref_rq, ref_overrun;
    logic [3:0]    sdram_cmd;
    logic [AW-1:0] sdram_addr;
    logic [1:0]    sdram_bank;

    always #5 clk = ~clk;

    sdram_arbit #(.REF_PERIOD(P), .TRP(TRP), .TRC(TRC), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .init_end(init_end), .init_cmd(init_cmd),
        .init_addr(init_addr), .wr_rq(wr_rq), .wr_end_flag(wr_end_flag),
        .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank_addr(wr_bank_addr),
        .rd_rq(rd_rq), .rd_end_flag(rd_end_flag), .rd_cmd(rd_cmd),
        .rd_addr(rd_addr), .rd_bank_addr(rd_bank_addr), .wr_en(wr_en),
        .rd_en(rd_en), .ref_rq(ref_rq), .ref_overrun(ref_overrun),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit rand_on = 1'b0;

    // Reference model: who owns the bus, edges elapsed since init finished,
    // and position inside the refresh sequence.
    int            m_mode = 0;   // 0 init, 1 idle, 2 refresh, 3 write, 4 read
    int            m_ticks = 0;
    int            m_k = 0;
    logic [3:0]    e_cmd = NOP;
    logic [AW-1:0] e_addr = '0;
    logic [1:0]    e_bank = '0;
    logic          e_wr = 0, e_rd = 0, e_ref = 0, e_ovr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit wrap, took, want_wr, want_rd;
        took = 1'b0;
        if (!rst_n) begin
            m_mode = 0; m_ticks = 0; m_k = 0;
            e_cmd = NOP; e_addr = '0; e_bank = '0;
            e_wr = 0; e_rd = 0; e_ref = 0; e_ovr = 0;
            return;
        end
        wrap = (m_mode != 0) && ((m_ticks % P) == P - 1);
        if (m_mode != 0) m_ticks++;
        e_wr = 0; e_rd = 0;
        e_cmd = NOP; e_addr = '0; e_bank = '0;
        case (m_mode)
            0: begin
                e_cmd = init_cmd; e_addr = init_addr;
                if (init_end) m_mode = 1;
            end
            1: begin
                want_wr = wr_rq && !(RD_PRI && rd_rq);
                want_rd = rd_rq && !want_wr;
                if (e_ref) begin m_mode = 2; m_k = 0; took = 1'b1; end
                else if (want_wr) begin m_mode = 3; e_wr = 1; end
                else if (want_rd) begin m_mode = 4; e_rd = 1; end
            end
            2: begin
                if (m_k == 0) begin e_cmd = PRE; e_addr = 12'h400; end
                else if (m_k == TRP) e_cmd = ARF;
                m_k++;
                if (m_k == TRP + TRC) m_mode = 1;
            end
            3: begin
                e_cmd = wr_cmd; e_addr = wr_addr; e_bank = wr_bank_addr;
                if (wr_end_flag) m_mode = 1;
            end
            default: begin
                e_cmd = rd_cmd; e_addr = rd_addr; e_bank = rd_bank_addr;
                if (rd_end_flag) m_mode = 1;
            end
        endcase
        if (wrap) begin
            if (e_ref) e_ovr = 1;
            e_ref = 1;
        end else if (took) begin
            e_ref = 0;
        end
    endtask

    task automatic rand_inputs();
        rst_n        = ($urandom_range(0, 299) != 0);
        init_end     = ($urandom_range(0, 3) == 0);
        init_cmd     = 4'($urandom);
        init_addr    = AW'($urandom);
        wr_rq        = ($urandom_range(0, 3) == 0);
        rd_rq        = ($urandom_range(0, 3) == 0);
        wr_end_flag  = ($urandom_range(0, 7) == 0);
        rd_end_flag  = ($urandom_range(0, 7) == 0);
        wr_cmd       = 4'($urandom);
        rd_cmd       = 4'($urandom);
        wr_addr      = AW'($urandom);
        rd_addr      = AW'($urandom);
        wr_bank_addr = 2'($urandom);
        rd_bank_addr = 2'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check("cmd",     32'(sdram_cmd),   32'(e_cmd));
        check("addr",    32'(sdram_addr),  32'(e_addr));
        check("bank",    32'(sdram_bank),  32'(e_bank));
        check("wr_en",   32'(wr_en),       32'(e_wr));
        check("rd_en",   32'(rd_en),       32'(e_rd));
        check("ref_rq",  32'(ref_rq),      32'(e_ref));
        check("ref_ovr", 32'(ref_overrun), 32'(e_ovr));
        if (rand_on) rand_inputs();
    endtask

    initial begin
        int cyc_init;
        bit saw_pre;
        bit got;

        // Reset, then init owns the bus for 20 cycles.
        repeat (2) step();
        check("rst_cmd", 32'(sdram_cmd), 32'(NOP));
        check("rst_ref", 32'(ref_rq), 32'd0);
        rst_n = 1'b1;
        repeat (20) step();
        check("init_follow", 32'(sdram_cmd), 32'h0);
        check("init_no_ref", 32'(ref_rq), 32'd0);

        // Simultaneous write/read request right after init.
        init_end = 1'b1; wr_rq = 1'b1; rd_rq = 1'b1;
        step();
        cyc_init = cyc;
        step();
        check("tie_wr_en", 32'(wr_en), 32'(!RD_PRI));
        check("tie_rd_en", 32'(rd_en), 32'(RD_PRI));
        wr_rq = 1'b0; rd_rq = 1'b0; wr_end_flag = 1'b1; rd_end_flag = 1'b1;
        step();
        check("grant_one_cycle", 32'(wr_en | rd_en), 32'd0);
        wr_end_flag = 1'b0; rd_end_flag = 1'b0;

        // Idle until the first refresh request.
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            step();
            got = ref_rq;
        end
        check("ref_rise_seen", 32'(got), 32'd1);
        check("ref_rise_time", 32'(cyc - cyc_init), 32'(P));
        step();
        check("ref_clr_on_entry", 32'(ref_rq), 32'd0);
        step();
        check("pre_cmd", 32'(sdram_cmd), 32'(PRE));
        check("pre_addr", 32'(sdram_addr), 32'h400);
        repeat (2) step();
        check("aref_cmd", 32'(sdram_cmd), 32'(ARF));
        repeat (6) step();

        // Long read spanning two refresh periods, with a write waiting.
        rd_rq = 1'b1;
        step();
        check("rd_grant", 32'(rd_en), 32'd1);
        rd_rq = 1'b0; wr_rq = 1'b1;
        repeat (1600) step();
        check("ovr_set", 32'(ref_overrun), 32'd1);
        check("ref_held", 32'(ref_rq), 32'd1);
        rd_end_flag = 1'b1;
        step();
        rd_end_flag = 1'b0;
        saw_pre = 1'b0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (sdram_cmd == PRE) saw_pre = 1'b1;
            got = wr_en;
        end
        check("wr_after_aref_got", 32'(got), 32'd1);
        check("wr_after_aref_pre", 32'(saw_pre), 32'd1);
        wr_rq = 1'b0; wr_end_flag = 1'b1;
        step();
        wr_end_flag = 1'b0;

        // Randomized traffic including occasional resets.
        rand_on = 1'b1;
        rand_inputs();
        repeat (4000) step();
        rand_on = 1'b0;
        rst_n = 1'b1; init_end = 1'b1; wr_rq = 1'b0; rd_rq = 1'b0;
        wr_end_flag = 1'b1; rd_end_flag = 1'b1;
        repeat (12) step();
        wr_end_flag = 1'b0; rd_end_flag = 1'b0;

        // Reset during the refresh sequence.
        got = ref_rq;
        for (int i = 0; i < 1000 && !got; i++) begin
            step();
            got = ref_rq;
        end
        check("ref_wait2", 32'(got), 32'd1);
        repeat (2) step();
        check("pre_before_rst", 32'(sdram_cmd), 32'(PRE));
        rst_n = 1'b0;
        step();
        check("rst_mid_cmd", 32'(sdram_cmd), 32'(NOP));
        check("rst_mid_ovr", 32'(ref_overrun), 32'd0);
        check("rst_mid_ref", 32'(ref_rq), 32'd0);
        rst_n = 1'b1; init_end = 1'b0; init_cmd = 4'b1010; init_addr = 12'h5A5;
        repeat (3) step();
        check("reinit_cmd", 32'(sdram_cmd), 32'hA);
        init_end = 1'b1;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
